// File: rtl/panel_pkg.sv
// Shared constants and the quadrature step decoder for the front-panel scanner.
package panel_pkg;

  // Cycles after reset release during which encoders only track position.
  localparam int ENC_PRIME_CYCLES = 3;

  // Button pins pull low when pressed.
  localparam logic KEY_ACTIVE = 1'b0;

  // One decoded encoder step: delta in {-1,0,+1} and an illegal-jump flag.
  typedef struct packed {
    logic signed [1:0] delta;
    logic              illegal;
  } quad_step_t;

  // Gray position of {A,B} along the forward sequence 00->01->11->10.
  function automatic logic [1:0] quad_pos(input logic [1:0] ab);
    logic [1:0] p;
    case (ab)
      2'b00:   p = 2'd0;
      2'b01:   p = 2'd1;
      2'b11:   p = 2'd2;
      default: p = 2'd3;
    endcase
    return p;
  endfunction

  // Position difference mod 4: +1 forward, 3 reverse, 2 means both phases flipped.
  function automatic quad_step_t quad_delta(input logic [1:0] prev, input logic [1:0] cur);
    quad_step_t r;
    logic [1:0] d;
    d = quad_pos(cur) - quad_pos(prev);
    r = '0;
    case (d)
      2'd1:    r.delta   = 2'sb01;
      2'd3:    r.delta   = 2'sb11;
      2'd2:    r.illegal = 1'b1;
      default: r.delta   = 2'sb00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/panel_quad_decoder.sv
// One quadrature encoder channel: sync, priming, wrapping count, sticky moved/err.
module panel_quad_decoder
  import panel_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             moved,
  output logic             err
);

  localparam int STAGES = ENC_PRIME_CYCLES - 1;

  logic [1:0]       ab_s1, ab_s2, prev;
  logic [STAGES:0]  vld_pipe;
  quad_step_t       step;
  logic [CNT_W-1:0] delta_ext, base;

  // Decode only once priming has filled prev with a real synced position.
  always_comb begin
    step      = '0;
    if (vld_pipe[STAGES]) step = quad_delta(prev, ab_s2);
    delta_ext = step.delta[1] ? '1 : {{(CNT_W-1){1'b0}}, step.delta[0]};
    base      = clr ? '0 : count;
  end

  // Sync, prime shift register, and count/flag update; a clear never drops a same-cycle step.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      ab_s1    <= '0;
      ab_s2    <= '0;
      prev     <= '0;
      vld_pipe <= '0;
      count    <= '0;
      moved    <= 1'b0;
      err      <= 1'b0;
    end else begin
      ab_s1    <= {enc_a, enc_b};
      ab_s2    <= ab_s1;
      prev     <= ab_s2;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      count    <= base + delta_ext;
      moved    <= (moved & ~clr) | (step.delta != 2'sb00);
      err      <= (err & ~clr) | step.illegal;
    end
  end

endmodule

// File: rtl/panel_input_scanner.sv
// Front-panel scanner: debounced keys with sticky press events, quadrature encoders, irq.
module panel_input_scanner
  import panel_pkg::*;
#(
  parameter int NUM_KEYS        = 12,
  parameter int NUM_ENC         = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 8
) (
  input  logic                     PLD_MCLK,
  input  logic                     EPL_RESETN,
  input  logic [NUM_KEYS-1:0]      key_raw,
  input  logic [NUM_ENC-1:0]       enc_a,
  input  logic [NUM_ENC-1:0]       enc_b,
  input  logic [NUM_KEYS-1:0]      key_evt_clr,
  input  logic [NUM_ENC-1:0]       enc_clr,
  output logic [NUM_KEYS-1:0]      key_state,
  output logic [NUM_KEYS-1:0]      key_event,
  output logic [NUM_ENC*CNT_W-1:0] enc_count,
  output logic [NUM_ENC-1:0]       enc_moved,
  output logic [NUM_ENC-1:0]       enc_err,
  output logic                     irq
);

  localparam int            DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_ENC-1:0][CNT_W-1:0] cnt_pk;

  // Per-key sync and debounce; stable resets released so no press appears at reset.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic            s1, s2, stable, evt;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge PLD_MCLK or negedge EPL_RESETN) begin
      if (!EPL_RESETN) begin
        s1     <= ~KEY_ACTIVE;
        s2     <= ~KEY_ACTIVE;
        stable <= ~KEY_ACTIVE;
        db_cnt <= '0;
        evt    <= 1'b0;
      end else begin
        s1 <= key_raw[i];
        s2 <= s1;
        if (s2 == stable) begin
          db_cnt <= '0;
          evt    <= evt & ~key_evt_clr[i];
        end else if (db_cnt == DB_MAX) begin
          stable <= s2;
          db_cnt <= '0;
          // Only the transition into the pressed level raises the event; set wins over clear.
          evt    <= (evt & ~key_evt_clr[i]) | (s2 == KEY_ACTIVE);
        end else begin
          db_cnt <= db_cnt + 1'b1;
          evt    <= evt & ~key_evt_clr[i];
        end
      end
    end

    assign key_state[i] = (stable == KEY_ACTIVE);
    assign key_event[i] = evt;
  end

  // One decoder per encoder channel.
  for (genvar e = 0; e < NUM_ENC; e++) begin : g_enc
    panel_quad_decoder #(.CNT_W(CNT_W)) u_dec (
      .gclk   (PLD_MCLK),
      .grst_n (EPL_RESETN),
      .enc_a  (enc_a[e]),
      .enc_b  (enc_b[e]),
      .clr    (enc_clr[e]),
      .count  (cnt_pk[e]),
      .moved  (enc_moved[e]),
      .err    (enc_err[e])
    );
  end

  assign enc_count = cnt_pk;

  // Registered interrupt: follows the sticky flags by one cycle.
  always_ff @(posedge PLD_MCLK or negedge EPL_RESETN) begin
    if (!EPL_RESETN) irq <= 1'b0;
    else             irq <= (|key_event) | (|enc_moved);
  end

endmodule

// File: doc/panel_input_scanner.md
# panel_input_scanner

Parametrised front-panel input block: synchronises, debounces and edge-latches NUM_KEYS push-buttons and decodes NUM_ENC quadrature encoders into wrapping signed counts. It sits between the panel pins and the EPL bus-to-IO bridge, which reads its status vectors and pulses its clear strobes. It replaces direct pin-to-port wiring, so software no longer polls raw, bouncing levels.

## Interface
- NUM_KEYS, 12, number of buttons (1..32)
- NUM_ENC, 2, number of quadrature encoders (1..8)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a key change (≥2; 1 ms at 50 MHz)
- CNT_W, 8, encoder count width (two's complement)
- PLD_MCLK  in  1  single clock, all logic rising-edge
- EPL_RESETN  in  1  asynchronous, active-low reset
- key_raw  in  NUM_KEYS  button pins, active-low (0 = pressed), asynchronous
- enc_a, enc_b  in  NUM_ENC each  encoder phases, asynchronous
- key_evt_clr  in  NUM_KEYS  1-cycle write-1-to-clear strobes for key_event
- enc_clr  in  NUM_ENC  1-cycle strobes: zero count, clear enc_moved/enc_err
- key_state  out  NUM_KEYS  debounced level, 1 = pressed
- key_event  out  NUM_KEYS  sticky press flag
- enc_count  out  NUM_ENC*CNT_W  packed counts, encoder i at [i*CNT_W +: CNT_W]
- enc_moved  out  NUM_ENC  sticky: count changed since last clear
- enc_err  out  NUM_ENC  sticky: illegal transition (both phases changed)
- irq  out  1  registered OR of key_event and enc_moved

## Operation
- Reset values: key_state 0, key_event 0, enc_count 0, enc_moved 0, enc_err 0, irq 0. Key sync flops and the stable register reset to 1 (released). Encoder sync flops reset to 0.
- Every input passes through a 2-flop synchroniser.
- Debounce, per key: counter width $clog2(DEBOUNCE_CYCLES).
  - Synced value equals stable: counter is reset to 0.
  - Otherwise the counter increments. On the cycle where it equals DEBOUNCE_CYCLES-1 with a mismatch still present, stable takes the synced value and the counter resets to 0.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
  - key_state = ~stable.
- key_event[i] is set on a stable 1→0 (press) transition only; releases do not set it. It is cleared by key_evt_clr[i]. A simultaneous set and clear leaves the flag set.
- Encoder, per channel, 4x decoding. The prev register holds the previous synced {A,B}.
  - Forward sequence 00→01→11→10→00 adds +1; the reverse sequence adds −1.
  - No change adds 0.
  - Both bits changing adds 0 and sets enc_err.
  - The count wraps modulo 2^CNT_W: 127+1 = −128 at CNT_W=8.
- Priming: for the first 3 cycles after reset deassertion, prev loads the synced value with no count or error. This prevents a false error when the encoder rests at a position other than 00.
- enc_clr with a simultaneous step: count loads 0+delta, so no step is lost. enc_moved is set if delta≠0, otherwise cleared. enc_err is cleared unless the same cycle is illegal.
- enc_moved is set whenever delta≠0.

## Timing
- Key pin edge to key_state change: 2 sync cycles + DEBOUNCE_CYCLES cycles.
- key_event rises in the same cycle as key_state. irq rises one cycle later.
- Encoder pin edge to enc_count update: 3 cycles (2 sync + 1 decode register). enc_moved updates in the same cycle as the count; irq follows one cycle later.
- Clear strobes take effect on the next edge. irq drops one cycle after the last flag clears.
- Reset asserted mid-debounce or mid-count: all state returns immediately to reset values. Priming restarts on release.

## Structure
- Package panel_pkg holds:
  - the quadrature delta function (2-bit prev, 2-bit cur → delta in {−1,0,+1} plus illegal bit);
  - the ENC_PRIME_CYCLES=3 constant;
  - the key polarity constant KEY_ACTIVE=1'b0.
- Sub-module panel_quad_decoder holds one encoder's sync, prime, count, moved and err logic. It is instantiated NUM_ENC times in a generate loop.
- Key debounce stays inline in a generate loop.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, CNT_W=8, NUM_KEYS=12, NUM_ENC=2.
- Press key_raw[3] and hold → key_state[3]=1 and key_event[3]=1 exactly 6 cycles after the edge; irq=1 at cycle 7. key_evt_clr[3] → key_event[3]=0 and irq=0 one cycle later.
- key_raw[0] low for 3 cycles then high → key_state and key_event stay 0. Release bounce of 2 cycles while held → key_state stays 1 and no second event.
- Encoder 0 driven 00→01→11→10→00 (one phase change every 8 cycles) → enc_count[7:0]=4 and enc_moved[0]=1. The reverse sequence ×5 → 0xFF (−1).
- Encoder 1 preloaded to 127 via 127 forward steps, then 1 more → 0x80. Jump 00→11 → enc_err[1]=1 with the count unchanged.
- enc_clr[0] in the same cycle as a +1 step → count=1, enc_moved[0]=1.
- Encoder resting at 11 through reset release → no enc_err and count=0. EPL_RESETN pulsed low mid-debounce → all outputs 0 immediately.
